// File: rtl/nqcpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nqcpu_pkg
// Description : Shared types and constants for the nqcpu memory port:
//               FSM state encoding, requester grant encoding, default bus
//               widths and the wait-counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package nqcpu_pkg;

   localparam int unsigned c_ADDR_W_DEF     = 16;
   localparam int unsigned c_DATA_W_DEF     = 16;
   localparam int unsigned c_WAIT_LIMIT_DEF = 255;

   typedef enum logic [1:0] {
      MP_IDLE   = 2'd0,
      MP_ACCESS = 2'd1,
      MP_DONE   = 2'd2
   } mp_state_e;

   typedef enum logic {
      GNT_FETCH = 1'b0,
      GNT_DATA  = 1'b1
   } mp_gnt_e;

   // Counter must hold values 0..limit; a disabled limit (0) still needs one
   // bit so the counter port is never zero-width.
   function automatic int unsigned wait_cnt_width(input int unsigned limit);
      return (limit == 0) ? 1 : $clog2(limit + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/nqcpu_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : nqcpu_wait_timer
// Description : Loadable saturating wait-state counter. Flags limit_hit_o
//               once the count equals WAIT_LIMIT; a WAIT_LIMIT of 0 disables
//               the flag entirely.
// Ports       : clk, rst_n      - clock, async active-low reset
//               load_i          - load load_val_i (takes priority over inc_i)
//               load_val_i      - value to load
//               inc_i           - count one wait cycle
//               limit_hit_o     - count has reached WAIT_LIMIT
// Revision    : 1.0 - initial release
// ============================================================================
module nqcpu_wait_timer
   import nqcpu_pkg::*;
#(
   parameter int unsigned WAIT_LIMIT = c_WAIT_LIMIT_DEF,
   parameter int unsigned CNT_W      = wait_cnt_width(WAIT_LIMIT)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             inc_i,
   output logic             limit_hit_o
);

   localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Saturate rather than wrap so a disabled limit never produces a false hit
   // or a counter that restarts from zero mid-access.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (inc_i && (cnt_q != c_CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   generate
      if (WAIT_LIMIT == 0) begin : g_no_limit
         assign limit_hit_o = 1'b0;
      end else begin : g_limit
         localparam logic [CNT_W-1:0] c_LIMIT = CNT_W'(WAIT_LIMIT);
         assign limit_hit_o = (cnt_q == c_LIMIT);
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/nqcpu_mem_port.sv
`default_nettype none
// ============================================================================
// Module      : nqcpu_mem_port
// Description : Single-port memory interface arbitrating fetch (read-only)
//               and data (load/store) requests onto one external bus, with
//               byte-lane writes, wait states and a bounded wait timeout.
// Ports       : f_req_i/f_addr_i/f_ack_o/f_rdata_o     - fetch requester
//               d_req_i/d_we_i/d_addr_i/d_wdata_i/d_be_i,
//               d_ack_o/d_rdata_o                      - data requester
//               err_o                                  - ack was a timeout
//               addr_o/re_o/we_o/be_o/data_io/wait_i   - external bus
// Revision    : 1.0 - initial release
// ============================================================================
module nqcpu_mem_port
   import nqcpu_pkg::*;
#(
   parameter int unsigned ADDR_W     = c_ADDR_W_DEF,
   parameter int unsigned DATA_W     = c_DATA_W_DEF,
   parameter int unsigned WAIT_LIMIT = c_WAIT_LIMIT_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                f_req_i,
   input  logic [ADDR_W-1:0]   f_addr_i,
   output logic                f_ack_o,
   output logic [DATA_W-1:0]   f_rdata_o,
   input  logic                d_req_i,
   input  logic                d_we_i,
   input  logic [ADDR_W-1:0]   d_addr_i,
   input  logic [DATA_W-1:0]   d_wdata_i,
   input  logic [DATA_W/8-1:0] d_be_i,
   output logic                d_ack_o,
   output logic [DATA_W-1:0]   d_rdata_o,
   output logic                err_o,
   output logic [ADDR_W-1:0]   addr_o,
   output logic                re_o,
   output logic                we_o,
   output logic [DATA_W/8-1:0] be_o,
   inout  wire  [DATA_W-1:0]   data_io,
   input  logic                wait_i
);

   localparam int unsigned c_BE_W = DATA_W / 8;
   localparam int unsigned c_CNT_W = wait_cnt_width(WAIT_LIMIT);

   mp_state_e           state_q;
   mp_gnt_e             gnt_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [c_BE_W-1:0]   be_q;
   logic                re_q;
   logic                we_q;
   logic                f_ack_q;
   logic                d_ack_q;
   logic                err_q;
   logic [DATA_W-1:0]   f_rdata_q;
   logic [DATA_W-1:0]   d_rdata_q;

   logic                w_in_access;
   logic                w_timeout;
   logic                w_finish;
   logic [DATA_W-1:0]   w_rdata;

   assign w_in_access = (state_q == MP_ACCESS);

   // Timer is held at zero outside ACCESS, so every access starts fresh.
   nqcpu_wait_timer #(
      .WAIT_LIMIT (WAIT_LIMIT),
      .CNT_W      (c_CNT_W)
   ) u_wait_timer (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_i      (!w_in_access),
      .load_val_i  ('0),
      .inc_i       (w_in_access && wait_i),
      .limit_hit_o (w_timeout)
   );

   // The access ends on a ready edge, or on a still-waiting edge once the
   // limit has been reached; in the latter case the read data is discarded.
   assign w_finish = !wait_i || w_timeout;
   assign w_rdata  = wait_i ? '0 : data_io;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= MP_IDLE;
         gnt_q     <= GNT_FETCH;
         addr_q    <= '0;
         wdata_q   <= '0;
         be_q      <= '0;
         re_q      <= 1'b0;
         we_q      <= 1'b0;
         f_ack_q   <= 1'b0;
         d_ack_q   <= 1'b0;
         err_q     <= 1'b0;
         f_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         case (state_q)
            MP_IDLE: begin
               // Data wins ties: it belongs to the older instruction.
               if (d_req_i) begin
                  gnt_q   <= GNT_DATA;
                  addr_q  <= d_addr_i;
                  wdata_q <= d_wdata_i;
                  be_q    <= d_be_i;
                  we_q    <= d_we_i;
                  re_q    <= !d_we_i;
                  state_q <= MP_ACCESS;
               end else if (f_req_i) begin
                  gnt_q   <= GNT_FETCH;
                  addr_q  <= f_addr_i;
                  be_q    <= '1;
                  we_q    <= 1'b0;
                  re_q    <= 1'b1;
                  state_q <= MP_ACCESS;
               end
            end

            MP_ACCESS: begin
               if (w_finish) begin
                  re_q    <= 1'b0;
                  we_q    <= 1'b0;
                  err_q   <= wait_i;
                  state_q <= MP_DONE;
                  if (gnt_q == GNT_DATA) begin
                     d_ack_q <= 1'b1;
                     if (re_q) begin
                        d_rdata_q <= w_rdata;
                     end
                  end else begin
                     f_ack_q   <= 1'b1;
                     f_rdata_q <= w_rdata;
                  end
               end
            end

            MP_DONE: begin
               f_ack_q <= 1'b0;
               d_ack_q <= 1'b0;
               err_q   <= 1'b0;
               state_q <= MP_IDLE;
            end

            default: begin
               state_q <= MP_IDLE;
            end
         endcase
      end
   end

   assign addr_o    = addr_q;
   assign be_o      = be_q;
   assign re_o      = re_q;
   assign we_o      = we_q;
   assign f_ack_o   = f_ack_q;
   assign d_ack_o   = d_ack_q;
   assign err_o     = err_q;
   assign f_rdata_o = f_rdata_q;
   assign d_rdata_o = d_rdata_q;

   // Bus is released whenever no write strobe is active, including in reset.
   assign data_io = we_q ? wdata_q : {DATA_W{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_nqcpu_mem_port.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_nqcpu_mem_port
// Description : Scoreboard bench for nqcpu_mem_port. A sequencer issues
//               random fetch/data requests and pushes expected bus accesses
//               and responses; a bus device and an ack monitor check them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nqcpu_mem_port;

   localparam int unsigned WL = 4;

   typedef struct {
      logic [15:0] addr;
      logic        we;
      logic [1:0]  be;
      logic [15:0] wdata;
      int unsigned waits;
   } bus_t;

   typedef struct {
      logic [15:0] rdata;
      logic        is_load;
      logic        err;
      int unsigned ack_edge;
   } rsp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vectors = 0;
   int miscompares = 0;

   // ---------------- main DUT (WAIT_LIMIT = 4) ----------------
   logic        f_req = 0, d_req = 0, d_we = 0, wait_r = 0;
   logic [15:0] f_addr = 0, d_addr = 0, d_wdata = 0, bus_rd = 0;
   logic [1:0]  d_be = 0;
   logic        f_ack, d_ack, err, re, we;
   logic [15:0] f_rdata, d_rdata, addr_o;
   logic [1:0]  be;
   wire  [15:0] data_io;

   assign data_io = re ? bus_rd : 16'hzzzz;

   nqcpu_mem_port #(.ADDR_W(16), .DATA_W(16), .WAIT_LIMIT(WL)) dut (
      .clk(clk), .rst_n(rst_n),
      .f_req_i(f_req), .f_addr_i(f_addr), .f_ack_o(f_ack), .f_rdata_o(f_rdata),
      .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
      .d_be_i(d_be), .d_ack_o(d_ack), .d_rdata_o(d_rdata), .err_o(err),
      .addr_o(addr_o), .re_o(re), .we_o(we), .be_o(be), .data_io(data_io),
      .wait_i(wait_r)
   );

   // ---------------- second DUT (timeout disabled) ----------------
   logic        d0_req = 0, wait0 = 0;
   logic [15:0] bus0_rd = 0;
   logic        f0_ack, d0_ack, err0, re0, we0;
   logic [15:0] f0_rdata, d0_rdata, addr0;
   logic [1:0]  be0;
   wire  [15:0] data_io0;

   assign data_io0 = re0 ? bus0_rd : 16'hzzzz;

   nqcpu_mem_port #(.ADDR_W(16), .DATA_W(16), .WAIT_LIMIT(0)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .f_req_i(1'b0), .f_addr_i(16'h0), .f_ack_o(f0_ack), .f_rdata_o(f0_rdata),
      .d_req_i(d0_req), .d_we_i(1'b0), .d_addr_i(16'h0042), .d_wdata_i(16'h0),
      .d_be_i(2'b11), .d_ack_o(d0_ack), .d_rdata_o(d0_rdata), .err_o(err0),
      .addr_o(addr0), .re_o(re0), .we_o(we0), .be_o(be0), .data_io(data_io0),
      .wait_i(wait0)
   );

   // ---------------- scoreboard state ----------------
   bus_t        bus_q[$];
   rsp_t        f_q[$];
   rsp_t        d_q[$];
   logic [15:0] mem_ref[16];
   logic [15:0] bus_mem[16];
   int unsigned free_edge = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Reference model: one shared bus, accesses serialised in grant order.
   // An access occupies grant..grant+2+waits edges; more than WL waits abort.
   task automatic model(input logic [15:0] a, input logic w, input logic [1:0] b,
                        input logic [15:0] wd, input int unsigned waits,
                        input int unsigned req_edge, output rsp_t r);
      int unsigned g, m;
      m = (waits > WL) ? WL : waits;
      g = (req_edge > free_edge) ? req_edge : free_edge;
      r.ack_edge = g + 1 + m;
      free_edge  = g + 3 + m;
      r.err      = (waits > WL);
      r.is_load  = !w;
      r.rdata    = 16'h0;
      if (!r.err) begin
         if (w) begin
            if (b[0]) mem_ref[a[3:0]][7:0]  = wd[7:0];
            if (b[1]) mem_ref[a[3:0]][15:8] = wd[15:8];
         end else begin
            r.rdata = mem_ref[a[3:0]];
         end
      end
   endtask

   // ---------------- bus device ----------------
   logic        dev_active = 0;
   int unsigned dev_left = 0;
   bus_t        cur;

   always @(negedge clk) begin
      if (!(re || we)) begin
         dev_active = 0;
         wait_r = 1'($urandom_range(0, 1));   // must be ignored outside ACCESS
         bus_rd = 16'($urandom);
      end else begin
         if (!dev_active) begin
            dev_active = 1;
            cur.waits = 0;
            if (bus_q.size() == 0) begin
               fail_now("bus_unexpected_access");
            end else begin
               cur = bus_q.pop_front();
               chk("bus_addr", addr_o, cur.addr);
               chk("bus_we", we, cur.we);
               chk("bus_re", re, !cur.we);
               chk("bus_be", be, cur.be);
               if (cur.we) chk("bus_wdata", data_io, cur.wdata);
            end
            dev_left = cur.waits;
         end else if (dev_left > 0) begin
            dev_left--;
         end
         if (dev_left > 0) begin
            wait_r = 1'b1;
            bus_rd = 16'($urandom);
         end else begin
            wait_r = 1'b0;
            bus_rd = bus_mem[addr_o[3:0]];
            if (we) begin
               if (be[0]) bus_mem[addr_o[3:0]][7:0]  = data_io[7:0];
               if (be[1]) bus_mem[addr_o[3:0]][15:8] = data_io[15:8];
            end
         end
      end
   end

   // ---------------- ack monitor ----------------
   rsp_t mr;
   always @(negedge clk) begin
      if (rst_n) begin
         if (d_ack) begin
            if (d_q.size() == 0) begin
               fail_now("d_ack_unexpected");
            end else begin
               mr = d_q.pop_front();
               chk("d_ack_cycle", cyc, mr.ack_edge);
               chk("d_err", err, mr.err);
               if (mr.is_load) chk("d_rdata", d_rdata, mr.rdata);
            end
         end
         if (f_ack) begin
            if (f_q.size() == 0) begin
               fail_now("f_ack_unexpected");
            end else begin
               mr = f_q.pop_front();
               chk("f_ack_cycle", cyc, mr.ack_edge);
               chk("f_err", err, mr.err);
               chk("f_rdata", f_rdata, mr.rdata);
            end
         end
      end
   end

   // ---------------- sequencer ----------------
   // mode: 0 = fetch only, 1 = data only, 2 = both in the same cycle.
   // Entered #1 after a rising edge; returns #1 after a rising edge.
   task automatic run_txn(input int mode, input logic [15:0] fa, input logic dwe,
                          input logic [15:0] da, input logic [15:0] dwd,
                          input logic [1:0] dbe, input int unsigned wd,
                          input int unsigned wf);
      rsp_t r;
      bus_t b;
      int unsigned req_edge;
      req_edge = cyc + 1;
      if (mode != 0) begin
         b.addr = da; b.we = dwe; b.be = dbe; b.wdata = dwd; b.waits = wd;
         bus_q.push_back(b);
         model(da, dwe, dbe, dwd, wd, req_edge, r);
         d_q.push_back(r);
         d_addr = da; d_we = dwe; d_wdata = dwd; d_be = dbe; d_req = 1'b1;
      end
      if (mode != 1) begin
         b.addr = fa; b.we = 1'b0; b.be = 2'b11; b.wdata = 16'h0; b.waits = wf;
         bus_q.push_back(b);
         model(fa, 1'b0, 2'b11, 16'h0, wf, req_edge, r);
         f_q.push_back(r);
         f_addr = fa; f_req = 1'b1;
      end
      for (int k = 0; k < 100 && (f_req || d_req); k++) begin
         @(negedge clk);
         if (d_ack) d_req = 1'b0;
         if (f_ack) f_req = 1'b0;
      end
      if (f_req || d_req) begin
         fail_now("ack_timeout");
         f_req = 1'b0;
         d_req = 1'b0;
      end
      @(posedge clk);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
   endtask

   function automatic int unsigned rand_waits();
      return ($urandom_range(0, 3) == 0) ? $urandom_range(5, 8) : $urandom_range(0, 4);
   endfunction

   initial begin
      int unsigned e;
      int unsigned cnt;
      logic        done;
      for (int i = 0; i < 16; i++) begin
         mem_ref[i] = 16'($urandom);
         bus_mem[i] = mem_ref[i];
      end
      mem_ref[0] = 16'h1234;
      bus_mem[0] = 16'h1234;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_re", re, 0);
      chk("rst_we", we, 0);
      chk("rst_f_ack", f_ack, 0);
      chk("rst_d_ack", d_ack, 0);
      chk("rst_err", err, 0);
      chk("rst_addr", addr_o, 0);
      chk("rst_be", be, 0);
      chk("rst_f_rdata", f_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed cases first, then random traffic.
      run_txn(0, 16'h0010, 0, 0, 0, 2'b00, 0, 0);
      run_txn(2, 16'($urandom), 1'b1, 16'h0200, 16'hBEEF, 2'b10, 0, 0);
      run_txn(1, 0, 1'b0, 16'($urandom), 0, 2'b11, 3, 0);
      run_txn(1, 0, 1'b0, 16'($urandom), 0, 2'b11, 7, 0);
      run_txn(1, 0, 1'b0, 16'($urandom), 0, 2'b11, WL, 0);
      run_txn(2, 16'($urandom), 1'b0, 16'($urandom), 0, 2'b01, 6, 2);
      for (int it = 0; it < 150; it++) begin
         run_txn($urandom_range(0, 2), 16'($urandom), 1'($urandom),
                 16'($urandom), 16'($urandom), 2'($urandom),
                 rand_waits(), rand_waits());
      end

      // Reset in the middle of an access: strobe drops at once, no ack.
      bus_q.push_back('{addr: 16'h0033, we: 1'b0, be: 2'b11, wdata: 16'h0, waits: 5});
      d_addr = 16'h0033; d_we = 1'b0; d_be = 2'b11; d_req = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_mid_pre_re", re, 1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_re", re, 0);
      chk("rst_mid_we", we, 0);
      chk("rst_mid_d_ack", d_ack, 0);
      d_req = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      free_edge = 0;
      repeat (4) @(posedge clk);
      #1;
      chk("rst_mid_no_ack", d_ack, 0);
      run_txn(1, 0, 1'b1, 16'h0033, 16'hC0DE, 2'b11, 1, 0);
      run_txn(1, 0, 1'b0, 16'h0033, 0, 2'b11, 0, 0);

      // Timeout disabled: 300 wait cycles complete without error.
      wait0 = 1'b1;
      bus0_rd = 16'hDEAD;
      d0_req = 1'b1;
      e = cyc + 1;
      cnt = 0;
      done = 1'b0;
      for (int k = 0; k < 400 && !done; k++) begin
         @(negedge clk);
         if (d0_ack) begin
            chk("nolimit_ack_cycle", cyc, e + 1 + 300);
            chk("nolimit_err", err0, 0);
            chk("nolimit_rdata", d0_rdata, 16'hA5A5);
            d0_req = 1'b0;
            done = 1'b1;
         end else if (re0) begin
            cnt++;
            wait0 = (cnt <= 300);
            bus0_rd = wait0 ? 16'hDEAD : 16'hA5A5;
         end
      end
      if (!done) begin
         fail_now("nolimit_ack_timeout");
         d0_req = 1'b0;
      end

      repeat (3) @(posedge clk);
      #1;
      chk("bus_q_drained", bus_q.size(), 0);
      chk("f_q_drained", f_q.size(), 0);
      chk("d_q_drained", d_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
